// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
//   - host transmitter FSM state encoding
//   - keyboard command and response byte constants
//   - frame helpers: odd parity and frame bit selection
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    // bit_cnt value at which the stop bit is driven
    localparam logic [3:0] STOP_IDX = 4'd9;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bit of the host frame following the start bit: 0-7 data LSB first,
    // 8 parity, anything above is the stop bit (1).
    function automatic logic frame_bit(input logic [7:0] d, input logic par,
                                       input logic [3:0] idx);
        if (idx < 4'd8)
            return d[idx[2:0]];
        else if (idx == 4'd8)
            return par;
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus stability counter for one PS/2 pad.
// The output follows the synchronized input only after it has differed from
// the current output for 2^FILT_WIDTH consecutive cycles.
//   clk    : system clock
//   resetn : synchronous active-low reset (output resets to 1, idle bus)
//   din    : raw pad input
//   dout   : filtered, synchronized level
module ps2_line_filter #(
    parameter int FILT_WIDTH = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    logic [1:0]            sync;
    logic [FILT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (&cnt) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + FILT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus clock, issues the start bit, then shifts 8 data bits,
// odd parity and stop on device clock falling edges, samples the device ack
// and waits for the bus to go idle. A per-edge watchdog aborts stalled frames.
//   clk, resetn            : system clock, synchronous active-low reset
//   tx_data/tx_valid/tx_ready : command byte handshake
//   busy                   : high whenever a transfer is in progress
//   tx_done/tx_error       : single-cycle completion / failure pulses
//   ps2_clk_in/ps2_data_in : raw pad inputs
//   ps2_clk_oe/ps2_data_oe : open-drain pull-down enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILT_WIDTH     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state, state_next;
    logic             clk_f, data_f, clk_prev, fall;
    logic [7:0]       data_q;
    logic             par_q, err_flag;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic             accept, in_xfer, timeout, inhibit_end, finish_ok;
    logic             clk_oe_d, data_oe_d, ready_d, busy_d, done_d, error_d;

    ps2_line_filter #(.FILT_WIDTH(FILT_WIDTH)) u_clk_filt (
        .clk(clk), .resetn(resetn), .din(ps2_clk_in), .dout(clk_f)
    );

    ps2_line_filter #(.FILT_WIDTH(FILT_WIDTH)) u_data_filt (
        .clk(clk), .resetn(resetn), .din(ps2_data_in), .dout(data_f)
    );

    always_ff @(posedge clk) begin
        if (!resetn) clk_prev <= 1'b1;
        else         clk_prev <= clk_f;
    end

    assign fall        = clk_prev & ~clk_f;
    // tx_ready is only ever high while the FSM sits in IDLE
    assign accept      = tx_valid & tx_ready;
    assign in_xfer     = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    // a falling edge in the same cycle as the limit still counts as progress
    assign timeout     = in_xfer && !fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign inhibit_end = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
    assign finish_ok   = (state == ST_WAIT_IDLE) && clk_f && data_f;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state       <= state_next;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_ready    <= ready_d;
            busy        <= busy_d;
            tx_done     <= done_d;
            tx_error    <= error_d;
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept) state_next = ST_INHIBIT;
            ST_INHIBIT:   if (inhibit_end) state_next = ST_START;
            ST_START:     state_next = ST_SEND;
            ST_SEND: begin
                if (timeout)                          state_next = ST_IDLE;
                else if (fall && bit_cnt == STOP_IDX) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (timeout)   state_next = ST_IDLE;
                else if (fall) state_next = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: if (timeout || finish_ok) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Output next values
    always_comb begin
        clk_oe_d  = (state_next == ST_INHIBIT) || (state_next == ST_START);
        data_oe_d = ps2_data_oe;
        case (state_next)
            ST_IDLE, ST_INHIBIT: data_oe_d = 1'b0;
            ST_START:            data_oe_d = 1'b1;
            default: begin
                // start bit stays on the line until the first device edge
                if (state == ST_SEND && fall)
                    data_oe_d = ~frame_bit(data_q, par_q, bit_cnt);
            end
        endcase
        // ready returns one cycle after the done pulse, so the two never overlap
        ready_d = (state == ST_IDLE) && !accept;
        busy_d  = (state_next != ST_IDLE);
        done_d  = timeout || finish_ok;
        error_d = timeout || (finish_ok && err_flag);
    end

    // Frame datapath and shared inhibit / watchdog counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q   <= '0;
            par_q    <= 1'b0;
            err_flag <= 1'b0;
            bit_cnt  <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_q   <= tx_data;
                        par_q    <= odd_parity(tx_data);
                        err_flag <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_INHIBIT: cnt <= cnt + CNT_W'(1);
                ST_START: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                end
                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    cnt <= fall ? '0 : cnt + CNT_W'(1);
                    if (state == ST_SEND && fall) bit_cnt  <= bit_cnt + 4'd1;
                    if (state == ST_ACK && fall)  err_flag <= data_f;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model.
// Expected frame bits and error flags are queued when a command is issued and
// popped as the device model clocks the frame and as tx_done appears.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 5000;
    localparam int TMO  = 3000;
    localparam int FW   = 3;
    localparam int HALF = 100;   // device half clock period (scaled-down 12.5 kHz)

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b0;   // 1 = device pulls PS2_CLK low
    logic       dev_data = 1'b0;  // 1 = device pulls PS2_DATA low

    int   checks = 0, errors = 0;
    int   done_cnt = 0, acc_cnt = 0;
    logic clk_oe_prev = 1'b0;
    logic exp_bits[$];
    logic exp_err[$];

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
    assign ps2_data_in = ~(ps2_data_oe | dev_data);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILT_WIDTH(FW)) dut (
        .clk(clk), .resetn(resetn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (ps2_clk_oe === 1'b1 && clk_oe_prev === 1'b0) acc_cnt++;
        clk_oe_prev = ps2_clk_oe;
        if (tx_error === 1'b1) check("error_with_done", {31'd0, tx_done}, 32'd1);
    end

    // Issue one command and play the device side for nfalls clock pulses.
    // nfalls 0 = device silent, 11 = full frame, anything else stops mid-frame.
    task automatic send(input logic [7:0] d, input logic par, input bit ack,
                        input int nfalls, input bit keep_valid, input logic e_err,
                        output int elapsed);
        int n;
        elapsed = 0;
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(par);
        exp_bits.push_back(1'b1);
        exp_err.push_back(e_err);
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("accept_clk_low", {31'd0, ps2_clk_oe}, 32'd1);
        if (!keep_valid) tx_valid = 1'b0;
        check("busy_not_ready", {30'd0, tx_ready, busy}, 32'd1);
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < 20000) begin n++; @(negedge clk); end
        check("inhibit_len", n, INH + 1);
        check("start_bit_low", {31'd0, ps2_data_oe}, 32'd1);
        check("ready_mid", {31'd0, tx_ready}, 32'd0);
        if (nfalls > 0) begin
            repeat (50) @(negedge clk);
            for (int i = 1; i <= nfalls; i++) begin
                dev_clk = 1'b1;
                if (i == nfalls && nfalls < 11) begin
                    repeat (40) @(negedge clk);
                    break;
                end
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b0;
                if (i <= 10) begin
                    if (exp_bits.size() == 0) check("bit_queue", 32'd0, 32'd1);
                    else check($sformatf("frame_bit%0d", i - 1), {31'd0, ps2_data_in},
                               {31'd0, exp_bits.pop_front()});
                end
                if (i == 10 && ack) dev_data = 1'b1;
                if (i == 11) dev_data = 1'b0;
                if (i < 11) repeat (HALF) @(negedge clk);
            end
        end
        if (nfalls == 0 || nfalls >= 11) begin
            n = 0;
            while (tx_done !== 1'b1 && n < TMO + 2000) begin @(negedge clk); n++; end
            elapsed = n;
            check("done_seen", {31'd0, tx_done}, 32'd1);
            check("done_error", {31'd0, tx_error}, {31'd0, exp_err.pop_front()});
            @(negedge clk);
            check("released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            check("ready_after_done", {30'd0, tx_ready, tx_done}, 32'd2);
        end else begin
            void'(exp_err.pop_front());
        end
        exp_bits.delete();
    endtask

    initial begin
        int el, d0, a0;
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_hs", {28'd0, tx_ready, busy, tx_done, tx_error}, 32'h8);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_hs", {28'd0, tx_ready, busy, tx_done, tx_error}, 32'h8);

        // 0xED: bits 1,0,1,1,0,1,1,1 LSB first, parity 1, device acks
        send(CMD_SET_LEDS, 1'b1, 1'b1, 11, 1'b0, 1'b0, el);
        send(8'h01, 1'b0, 1'b1, 11, 1'b0, 1'b0, el);
        send(8'h00, 1'b1, 1'b1, 11, 1'b0, 1'b0, el);

        // missing ack
        send(8'h3C, 1'b1, 1'b0, 11, 1'b0, 1'b1, el);

        // device never clocks: watchdog fires TMO cycles after the clock release
        send(8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b1, el);
        check("timeout_len", el, TMO);

        // reset while bit 4 (0) of 0xA5 is on the line
        send(8'hA5, 1'b1, 1'b1, 5, 1'b0, 1'b0, el);
        check("bit4_driven", {31'd0, ps2_data_oe}, 32'd1);
        d0 = done_cnt;
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("midrst_hs", {29'd0, tx_ready, busy, tx_done}, 32'h4);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", {30'd0, tx_ready, ps2_clk_oe}, 32'd2);

        // tx_valid held high: one accept per completed transfer
        a0 = acc_cnt;
        d0 = done_cnt;
        send(CMD_RESET, 1'b1, 1'b1, 11, 1'b1, 1'b0, el);
        send(CMD_RESET, 1'b1, 1'b1, 11, 1'b1, 1'b0, el);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("held_accepts", acc_cnt - a0, 2);
        check("held_dones", done_cnt - d0, 2);
        check("held_idle", {30'd0, tx_ready, ps2_clk_oe}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(6_000_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
